// File: rtl/wb_ddr_bridge.sv
// -----------------------------------------------------------------------------
// wb_ddr_bridge
//
// Wishbone classic slave front end for ddr_controller. Each single 32-bit
// Wishbone read or write becomes exactly one controller command. The bridge
// carries the write data out and the read data back. It also schedules
// periodic auto-refresh (CMD_AR) between user accesses.
//
// Ports
//   clk, rst              single clock domain, async active-high reset
//   i_wbs_cyc/stb/we      Wishbone cycle, strobe, write enable
//   i_wbs_sel             byte selects (unused, every access is a full word)
//   i_wbs_adr, i_wbs_dat  word address and write data
//   o_wbs_dat, o_wbs_ack  read data and acknowledge
//   cmd, cmd_vld          controller command (READ=4, WRITE=5, AR=8) + strobe
//   addr, data_in         command address and write data to the controller
//   busy                  controller cannot take a command
//   data_req              controller consumes data_in this cycle
//   data_out, data_vld    read data from the controller
//   ddr_ready             controller initialisation done
//   timeout_err           sticky, set when a data phase times out
//
// States
//   state   | meaning
//   IDLE    | waiting for a Wishbone request or a pending refresh
//   ISSUE   | request latched, waiting for busy=0 to strobe the command
//   WDATA   | write issued, waiting for data_req (or timeout)
//   RDATA   | read issued, waiting for data_vld (or timeout)
//   ACK     | o_wbs_ack high until the master drops stb
//   REF     | refresh pending, waiting for busy=0 to strobe CMD_AR
// -----------------------------------------------------------------------------
module wb_ddr_bridge #(
    parameter int REFRESH_INTERVAL = 390,
    parameter int TIMEOUT          = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wbs_cyc,
    input  logic        i_wbs_stb,
    input  logic        i_wbs_we,
    input  logic [3:0]  i_wbs_sel,
    input  logic [31:0] i_wbs_adr,
    input  logic [31:0] i_wbs_dat,
    output logic [31:0] o_wbs_dat,
    output logic        o_wbs_ack,
    output logic [4:0]  cmd,
    output logic        cmd_vld,
    output logic [31:0] addr,
    output logic [31:0] data_in,
    input  logic        busy,
    input  logic        data_req,
    input  logic [31:0] data_out,
    input  logic        data_vld,
    input  logic        ddr_ready,
    output logic        timeout_err
);

    localparam logic [4:0] CMD_READ  = 5'd4;
    localparam logic [4:0] CMD_WRITE = 5'd5;
    localparam logic [4:0] CMD_AR    = 5'd8;

    localparam int RW = $clog2(REFRESH_INTERVAL + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WDATA = 3'd2,
        S_RDATA = 3'd3,
        S_ACK   = 3'd4,
        S_REF   = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [RW-1:0]  r_ref_cnt;
    logic           r_ref_pend;
    logic [TW-1:0]  r_to_cnt;
    logic [31:0]    r_adr;
    logic [31:0]    r_dat;
    logic           r_we;
    logic [4:0]     r_cmd;
    logic           r_cmd_vld;
    logic [31:0]    r_rdat;
    logic           r_to_err;

    logic           w_req;
    logic           w_ref_fire;
    logic           w_abort;
    logic           w_in_data;
    logic           w_data_done;
    logic           w_to_hit;
    logic           w_accept;
    logic           w_issue;
    logic           w_ref_issue;
    logic           w_unused_sel;

    assign w_unused_sel = ^i_wbs_sel;

    assign w_req       = i_wbs_cyc & i_wbs_stb;
    assign w_ref_fire  = ddr_ready && (r_ref_cnt == RW'(REFRESH_INTERVAL - 1));
    // Losing ddr_ready aborts everything except an ack already on the bus.
    assign w_abort     = !ddr_ready && (r_state != S_ACK);
    assign w_in_data   = (r_state == S_WDATA) || (r_state == S_RDATA);
    assign w_data_done = ddr_ready &&
                         (((r_state == S_WDATA) && data_req) ||
                          ((r_state == S_RDATA) && data_vld));
    // Data arriving on the last allowed cycle beats the timeout.
    assign w_to_hit    = ddr_ready && w_in_data && !w_data_done &&
                         (r_to_cnt == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // The wrap cycle itself counts as pending so refresh
                    // wins against a strobe sampled on that same edge.
                    if (r_ref_pend || w_ref_fire) begin
                        w_next = S_REF;
                    end else if (w_accept) begin
                        w_next = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!busy) begin
                        w_next = r_we ? S_WDATA : S_RDATA;
                    end
                end
                S_WDATA, S_RDATA: begin
                    if (w_data_done || w_to_hit) begin
                        w_next = S_ACK;
                    end
                end
                S_ACK: begin
                    if (!i_wbs_stb) begin
                        w_next = S_IDLE;
                    end
                end
                S_REF: begin
                    if (!busy) begin
                        w_next = S_IDLE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Output / strobe decode
    always_comb begin
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_ref_issue = 1'b0;
        o_wbs_ack   = 1'b0;
        case (r_state)
            S_IDLE:  w_accept    = ddr_ready && !r_ref_pend && !w_ref_fire && w_req;
            S_ISSUE: w_issue     = ddr_ready && !busy;
            S_REF:   w_ref_issue = ddr_ready && !busy;
            S_ACK:   o_wbs_ack   = 1'b1;
            default: ;
        endcase
    end

    // Datapath, command strobe, timers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref_cnt  <= '0;
            r_ref_pend <= 1'b0;
            r_to_cnt   <= '0;
            r_adr      <= '0;
            r_dat      <= '0;
            r_we       <= 1'b0;
            r_cmd      <= '0;
            r_cmd_vld  <= 1'b0;
            r_rdat     <= '0;
            r_to_err   <= 1'b0;
        end else begin
            r_cmd_vld <= w_issue | w_ref_issue;

            if (w_issue) begin
                r_cmd <= r_we ? CMD_WRITE : CMD_READ;
            end else if (w_ref_issue) begin
                r_cmd <= CMD_AR;
            end

            if (w_accept) begin
                r_adr <= i_wbs_adr;
                r_dat <= i_wbs_dat;
                r_we  <= i_wbs_we;
            end

            // The cycle carrying cmd_vld is not counted toward the timeout.
            if (w_issue) begin
                r_to_cnt <= '0;
            end else if (w_in_data && !r_cmd_vld && !w_to_hit && !w_data_done) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end

            if ((r_state == S_RDATA) && w_data_done) begin
                r_rdat <= data_out;
            end else if ((r_state == S_RDATA) && w_to_hit) begin
                r_rdat <= '0;
            end

            if (w_to_hit) begin
                r_to_err <= 1'b1;
            end

            // A wrap in the same cycle as the AR strobe keeps the flag set.
            if (w_abort) begin
                r_ref_cnt  <= '0;
                r_ref_pend <= 1'b0;
            end else if (ddr_ready) begin
                if (w_ref_fire) begin
                    r_ref_cnt  <= '0;
                    r_ref_pend <= 1'b1;
                end else begin
                    r_ref_cnt <= r_ref_cnt + RW'(1);
                    if (w_ref_issue) begin
                        r_ref_pend <= 1'b0;
                    end
                end
            end
        end
    end

    assign cmd         = r_cmd;
    assign cmd_vld     = r_cmd_vld;
    assign addr        = r_adr;
    assign data_in     = r_dat;
    assign o_wbs_dat   = r_rdat;
    assign timeout_err = r_to_err;

endmodule

// File: tb/tb_wb_ddr_bridge.sv
module tb_wb_ddr_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_wbs_cyc, i_wbs_stb, i_wbs_we;
    logic [3:0]  i_wbs_sel;
    logic [31:0] i_wbs_adr, i_wbs_dat;
    logic [31:0] o_wbs_dat;
    logic        o_wbs_ack;
    logic [4:0]  cmd;
    logic        cmd_vld;
    logic [31:0] addr, data_in;
    logic        busy, data_req, data_vld, ddr_ready;
    logic [31:0] data_out;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    wb_ddr_bridge #(.REFRESH_INTERVAL(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .i_wbs_cyc(i_wbs_cyc), .i_wbs_stb(i_wbs_stb), .i_wbs_we(i_wbs_we),
        .i_wbs_sel(i_wbs_sel), .i_wbs_adr(i_wbs_adr), .i_wbs_dat(i_wbs_dat),
        .o_wbs_dat(o_wbs_dat), .o_wbs_ack(o_wbs_ack),
        .cmd(cmd), .cmd_vld(cmd_vld), .addr(addr), .data_in(data_in),
        .busy(busy), .data_req(data_req), .data_out(data_out),
        .data_vld(data_vld), .ddr_ready(ddr_ready), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiesce();
        tick();
        ddr_ready = 1'b0;
        tick();
        ddr_ready = 1'b1;
    endtask

    task automatic wb_start(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        i_wbs_cyc = 1'b1;
        i_wbs_stb = 1'b1;
        i_wbs_we  = we;
        i_wbs_adr = adr;
        i_wbs_dat = dat;
    endtask

    task automatic wb_end();
        tick();
        i_wbs_cyc = 1'b0;
        i_wbs_stb = 1'b0;
        repeat (3) tick();
    endtask

    task automatic wait_cmd(output int c, output logic [4:0] k, output logic [31:0] a, output bit ok);
        ok = 1'b0; c = 0; k = '0; a = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmd_vld && cmd != 5'd8) begin
                c = cycle; k = cmd; a = addr; ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_ack(output int c, output bit ok);
        ok = 1'b0; c = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (o_wbs_ack) begin
                c = cycle; ok = 1'b1;
                return;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        repeat (2) tick();
        checks++;
        if ({o_wbs_dat, o_wbs_ack, cmd, cmd_vld, addr, data_in, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: dat=%h ack=%b cmd=%0d vld=%b addr=%h din=%h terr=%b, all required 0",
                     o_wbs_dat, o_wbs_ack, cmd, cmd_vld, addr, data_in, timeout_err);
        end
        rst = 1'b0; ddr_ready = 1'b1; busy = 1'b1;
        tick();
        wb_start(1'b1, 32'h0000_0040, 32'h1234_5678);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (addr !== 32'h0000_0040 || data_in !== 32'h1234_5678) begin
            errors++;
            $display("FAIL reset_latch: addr=%h din=%h, required 00000040 12345678", addr, data_in);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({addr, data_in, cmd_vld, o_wbs_ack, cmd} !== '0) begin
            errors++;
            $display("FAIL reset_async: addr=%h din=%h vld=%b ack=%b cmd=%0d, required all 0",
                     addr, data_in, cmd_vld, o_wbs_ack, cmd);
        end
        i_wbs_cyc = 1'b0; i_wbs_stb = 1'b0; busy = 1'b0;
        tick();
        rst = 1'b0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (cmd_vld) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL reset_no_cmd: %0d cmd_vld pulses after release, required 0", n);
        end
    endtask

    task automatic test_write();
        int start, c, extra;
        logic [4:0] k;
        logic [31:0] a;
        bit ok;
        quiesce();
        wb_start(1'b1, 32'h0000_0010, 32'hA5A5_1234);
        start = cycle;
        wait_cmd(c, k, a, ok);
        checks++;
        if (!ok || k !== 5'd5 || a !== 32'h0000_0010) begin
            errors++;
            $display("FAIL write_cmd: ok=%b cmd=%0d addr=%h, required 1 5 00000010", ok, k, a);
        end
        checks++;
        if (c - start !== 2) begin
            errors++;
            $display("FAIL write_cmd_latency: %0d cycles, required 2", c - start);
        end
        extra = 0;
        tick();
        repeat (2) begin
            @(negedge clk);
            if (cmd_vld) extra++;
            tick();
        end
        data_req = 1'b1;
        @(negedge clk);
        if (cmd_vld) extra++;
        checks++;
        if (data_in !== 32'hA5A5_1234 || o_wbs_ack !== 1'b0) begin
            errors++;
            $display("FAIL write_data_in: din=%h ack=%b, required a5a51234 0", data_in, o_wbs_ack);
        end
        tick();
        data_req = 1'b0;
        @(negedge clk);
        checks++;
        if (o_wbs_ack !== 1'b1) begin
            errors++;
            $display("FAIL write_ack: ack=%b, required 1", o_wbs_ack);
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL write_single_cmd: %0d extra cmd_vld, required 0", extra);
        end
        wb_end();
        checks++;
        if (o_wbs_ack !== 1'b0) begin
            errors++;
            $display("FAIL write_ack_drop: ack=%b, required 0", o_wbs_ack);
        end
    endtask

    task automatic test_read_back_to_back();
        int start, c, start2;
        logic [4:0] k;
        logic [31:0] a;
        bit ok;
        quiesce();
        wb_start(1'b0, 32'h0000_0020, 32'h0);
        start = cycle;
        wait_cmd(c, k, a, ok);
        checks++;
        if (!ok || k !== 5'd4 || a !== 32'h0000_0020) begin
            errors++;
            $display("FAIL read_cmd: ok=%b cmd=%0d addr=%h, required 1 4 00000020", ok, k, a);
        end
        tick();
        data_vld = 1'b1; data_out = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (o_wbs_ack !== 1'b0) begin
            errors++;
            $display("FAIL read_ack_early: ack=%b, required 0", o_wbs_ack);
        end
        tick();
        data_vld = 1'b0; data_out = 32'h0BAD_F00D;
        @(negedge clk);
        checks++;
        if (o_wbs_ack !== 1'b1 || o_wbs_dat !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read_data: ack=%b dat=%h, required 1 deadbeef", o_wbs_ack, o_wbs_dat);
        end
        checks++;
        if (cycle - start !== 4) begin
            errors++;
            $display("FAIL read_min_latency: %0d cycles, required 4", cycle - start);
        end
        tick();
        i_wbs_stb = 1'b0; i_wbs_cyc = 1'b0;
        tick();
        wb_start(1'b1, 32'h0000_0024, 32'h1111_2222);
        start2 = cycle;
        wait_cmd(c, k, a, ok);
        checks++;
        if (!ok || k !== 5'd5 || a !== 32'h0000_0024 || c - start2 !== 2) begin
            errors++;
            $display("FAIL back_to_back: ok=%b cmd=%0d addr=%h lat=%0d, required 1 5 00000024 2",
                     ok, k, a, c - start2);
        end
        tick();
        data_req = 1'b1;
        tick();
        data_req = 1'b0;
        @(negedge clk);
        checks++;
        if (o_wbs_ack !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_ack: ack=%b, required 1", o_wbs_ack);
        end
        wb_end();
    endtask

    task automatic test_refresh();
        int start, n;
        int ev_cyc[3];
        logic [4:0] ev_cmd[3];
        quiesce();
        repeat (7) tick();
        wb_start(1'b0, 32'h0000_0028, 32'h0);
        start = cycle;
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            @(negedge clk);
            if (cmd_vld) begin
                ev_cyc[n] = cycle; ev_cmd[n] = cmd; n++;
            end
        end
        checks++;
        if (n !== 2 || ev_cmd[0] !== 5'd8 || ev_cyc[0] - start !== 2) begin
            errors++;
            $display("FAIL refresh_first: n=%0d cmd=%0d lat=%0d, required 2 8 2", n, ev_cmd[0], ev_cyc[0] - start);
        end
        checks++;
        if (ev_cmd[1] !== 5'd4 || ev_cyc[1] - start !== 4) begin
            errors++;
            $display("FAIL refresh_then_read: cmd=%0d lat=%0d, required 4 4", ev_cmd[1], ev_cyc[1] - start);
        end
        tick();
        data_vld = 1'b1; data_out = 32'h5555_AAAA;
        tick();
        data_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (o_wbs_ack !== 1'b1 || o_wbs_dat !== 32'h5555_AAAA) begin
            errors++;
            $display("FAIL refresh_read_data: ack=%b dat=%h, required 1 5555aaaa", o_wbs_ack, o_wbs_dat);
        end
        wb_end();
        quiesce();
        n = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(negedge clk);
            if (cmd_vld && cmd == 5'd8) begin
                ev_cyc[n] = cycle; n++;
            end
        end
        checks++;
        if (n !== 3 || ev_cyc[1] - ev_cyc[0] !== 8 || ev_cyc[2] - ev_cyc[1] !== 8) begin
            errors++;
            $display("FAIL refresh_period: n=%0d gaps=%0d,%0d, required 3 8,8",
                     n, ev_cyc[1] - ev_cyc[0], ev_cyc[2] - ev_cyc[1]);
        end
    endtask

    task automatic test_busy();
        int n;
        quiesce();
        busy = 1'b1;
        wb_start(1'b1, 32'h0000_0050, 32'h0F0F_0F0F);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (cmd_vld) n++;
        end
        tick();
        busy = 1'b0;
        @(negedge clk);
        if (cmd_vld) n++;
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL busy_hold: %0d cmd_vld while busy, required 0", n);
        end
        @(negedge clk);
        checks++;
        if (cmd_vld !== 1'b1 || cmd !== 5'd5 || addr !== 32'h0000_0050) begin
            errors++;
            $display("FAIL busy_release: vld=%b cmd=%0d addr=%h, required 1 5 00000050", cmd_vld, cmd, addr);
        end
        @(negedge clk);
        checks++;
        if (cmd_vld !== 1'b0) begin
            errors++;
            $display("FAIL busy_single_pulse: vld=%b, required 0", cmd_vld);
        end
        tick();
        data_req = 1'b1;
        tick();
        data_req = 1'b0;
        @(negedge clk);
        checks++;
        if (o_wbs_ack !== 1'b1) begin
            errors++;
            $display("FAIL busy_ack: ack=%b, required 1", o_wbs_ack);
        end
        wb_end();
    endtask

    task automatic test_ready_drop();
        int n, c;
        logic [4:0] k;
        logic [31:0] a;
        bit ok;
        quiesce();
        busy = 1'b1;
        wb_start(1'b0, 32'h0000_0030, 32'h0);
        tick();
        tick();
        ddr_ready = 1'b0;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (cmd_vld || o_wbs_ack) n++;
            tick();
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL ready_drop_quiet: %0d cycles with cmd_vld/ack, required 0", n);
        end
        ddr_ready = 1'b1; busy = 1'b0;
        wait_cmd(c, k, a, ok);
        checks++;
        if (!ok || k !== 5'd4 || a !== 32'h0000_0030) begin
            errors++;
            $display("FAIL ready_drop_reissue: ok=%b cmd=%0d addr=%h, required 1 4 00000030", ok, k, a);
        end
        tick();
        data_vld = 1'b1; data_out = 32'h3030_3030;
        tick();
        data_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (o_wbs_ack !== 1'b1 || o_wbs_dat !== 32'h3030_3030) begin
            errors++;
            $display("FAIL ready_drop_data: ack=%b dat=%h, required 1 30303030", o_wbs_ack, o_wbs_dat);
        end
        wb_end();
    endtask

    task automatic test_timeout();
        int c, ca;
        logic [4:0] k;
        logic [31:0] a;
        bit ok, oka;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err_clear_before: terr=%b, required 0", timeout_err);
        end
        quiesce();
        data_out = 32'hCAFE_F00D;
        wb_start(1'b0, 32'h0000_0060, 32'h0);
        wait_cmd(c, k, a, ok);
        wait_ack(ca, oka);
        checks++;
        if (!ok || !oka || ca - c !== 17) begin
            errors++;
            $display("FAIL timeout_latency: cmd_ok=%b ack_ok=%b lat=%0d, required 1 1 17", ok, oka, ca - c);
        end
        checks++;
        if (o_wbs_dat !== 32'h0 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_result: dat=%h terr=%b, required 00000000 1", o_wbs_dat, timeout_err);
        end
        wb_end();
        repeat (5) tick();
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: terr=%b, required 1", timeout_err);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err_reset: terr=%b, required 0", timeout_err);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_wbs_cyc = 1'b0; i_wbs_stb = 1'b0; i_wbs_we = 1'b0;
        i_wbs_sel = 4'hF; i_wbs_adr = '0; i_wbs_dat = '0;
        busy = 1'b0; data_req = 1'b0; data_vld = 1'b0; data_out = '0;
        ddr_ready = 1'b0;

        test_reset();
        test_write();
        test_read_back_to_back();
        test_refresh();
        test_busy();
        test_ready_drop();
        test_timeout();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_ddr_bridge.md
# wb_ddr_bridge

Wishbone classic slave front end for `ddr_controller`: converts single 32-bit Wishbone reads and writes into one controller command each, and moves the write or read data across. It also owns the periodic auto-refresh schedule, inserting `CMD_AR` requests between user accesses. It sits between the Wishbone interconnect and `ddr_controller`, driving its `cmd`/`cmd_vld`/`addr`/`data_in` inputs and consuming `busy`/`data_req`/`data_out`/`data_vld`/`ddr_ready`.

## Interface
- `REFRESH_INTERVAL`, 390: cycles between refresh requests (7.8 µs at 50 MHz).
- `TIMEOUT`, 1024: maximum cycles spent waiting for `data_req` or `data_vld` before the access is force-acked.
- `clk` in 1: system clock; everything is in this single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `i_wbs_cyc`, `i_wbs_stb`, `i_wbs_we` in 1: Wishbone cycle, strobe and write enable.
- `i_wbs_sel` in 4: byte selects. Ignored; every access is a full word.
- `i_wbs_adr` in 32: word address, passed through unchanged to `addr`.
- `i_wbs_dat` in 32: write data.
- `o_wbs_dat` out 32: read data.
- `o_wbs_ack` out 1: Wishbone acknowledge.
- `cmd` out 5: controller command. Values: READ=4, WRITE=5, AR=8.
- `cmd_vld` out 1: command strobe, asserted for exactly 1 cycle per command.
- `addr` out 32: command address.
- `data_in` out 32: write data to the controller.
- `busy` in 1: controller cannot accept a command.
- `data_req` in 1: controller consumes `data_in` this cycle.
- `data_out` in 32: read data from the controller.
- `data_vld` in 1: `data_out` is valid this cycle.
- `ddr_ready` in 1: controller initialization is complete.
- `timeout_err` out 1: sticky flag, set on any timeout and cleared only by `rst`.

## Operation
- **Reset values:** all outputs are 0; state is IDLE; refresh counter is 0; refresh-pending flag is 0; timeout counter is 0.
- **Refresh counter:** runs only while `ddr_ready`=1. When it reaches `REFRESH_INTERVAL`-1 it sets `ref_pend` and wraps to 0. If `ref_pend` is already set when it fires again, the flag stays 1; requests do not accumulate.
- **IDLE:**
  - If `ref_pend`=1, go to REF. Refresh wins when it coincides with `stb`.
  - Else, if `i_wbs_cyc & i_wbs_stb` and `o_wbs_ack`=0: latch the address, `we` and write data, then go to ISSUE.
- **ISSUE:**
  - While `busy`=1, wait.
  - When `busy`=0: drive `cmd_vld`=1 for one cycle with `cmd`=5 (write) or 4 (read) and `addr`=latched address.
  - Then go to WDATA (write) or RDATA (read) and clear the timeout counter.
- **WDATA:** `data_in` holds the latched data. On `data_req`=1, go to ACK.
- **RDATA:** on `data_vld`=1, load `o_wbs_dat`<=`data_out` and go to ACK.
- **Timeout:** in WDATA or RDATA, when the counter reaches `TIMEOUT`-1:
  - set `timeout_err`;
  - for a read, load `o_wbs_dat`<=0;
  - go to ACK.
- **ACK:** `o_wbs_ack`=1. When `i_wbs_stb`=0, drop ack and go to IDLE. A master holding `stb` keeps ack high.
- **REF:**
  - While `busy`=1, wait.
  - When `busy`=0: drive `cmd_vld`=1 with `cmd`=8 for one cycle, clear `ref_pend`, return to IDLE.
  - If a counter wrap lands in that same cycle, the set wins.
- **Refresh during a transaction:** `ref_pend` is held and serviced on the next IDLE visit.
- **`ddr_ready` falls in any state except ACK:**
  - go to IDLE, drop `cmd_vld`, and clear the refresh counter and `ref_pend`;
  - no ack is produced; a strobe still held is re-issued once `ddr_ready` returns.
- **`rst` mid-operation:** all state is cleared immediately.

## Timing
- `cmd_vld` is registered. With `busy`=0 it rises 2 cycles after `stb` is first sampled in IDLE (IDLE→ISSUE, then ISSUE drives it).
- **Write ack:** rises 1 cycle after the `data_req` sample.
- **Read ack:** rises 1 cycle after the `data_vld` sample; `o_wbs_dat` is valid in the same cycle as ack.
- **Minimum latency, stb to ack:** 4 cycles when `data_req`/`data_vld` arrives 1 cycle after `cmd_vld`.
- **Back-to-back accesses:** the next access can start 1 cycle after `stb` is deasserted.
- **`data_req`/`data_vld` outside WDATA/RDATA:** ignored.

## Test plan
- **Reset:** assert `rst` asynchronously mid-ISSUE. Required: all outputs go to 0 at once, and no `cmd_vld` appears after release.
- **Write:** `ddr_ready`=1, write to adr 0x00000010 with data 0xA5A5_1234, `busy`=0, `data_req` 3 cycles after `cmd_vld`. Required:
  - one `cmd_vld` with `cmd`=5 and `addr`=0x10;
  - `data_in`=0xA5A51234 while `data_req` is high;
  - `o_wbs_ack` 1 cycle later.
- **Read:** read adr 0x20; `data_vld` with `data_out`=0xDEADBEEF. Required: `cmd`=4, `o_wbs_dat`=0xDEADBEEF, and ack in the same cycle.
- **Refresh vs. access:** `REFRESH_INTERVAL`=8, and `stb` is raised in the same cycle the refresh counter wraps. Required: `cmd`=8 is issued first, the read command follows, and exactly one AR is issued per 8 ready cycles.
- **Busy:** hold `busy`=1 for 5 cycles during ISSUE. Required: `cmd_vld` stays low, then is a single pulse on the first cycle with `busy`=0.
- **Timeout:** `TIMEOUT`=16, read with `data_vld` never asserted. Required: ack 17 cycles after `cmd_vld`, `o_wbs_dat`=0, `timeout_err`=1 and staying set.
